multicycle_ctrl: RTL and testbench

Multicycle control FSM that produces the 3-bit aluOp, operand-select and memory/register strobes consumed by the datapath ALU.
Sequences each instruction through fetch, decode, execute, memory and writeback. Waits on a memory ready handshake, with a timeout that traps to a sticky fault.
Sits between instruction memory/IR and the ALU/register-file datapath.

---
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: steps each instruction through fetch/decode/execute/memory/writeback,
// drives ALU op, operand selects and memory/register strobes; a stalled memory traps to FAULT.
module multicycle_ctrl #(
  parameter int INSTR_W     = 16,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_we,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               addr_sel,
  output logic               alu_src,
  output logic [2:0]         alu_op,
  output logic               reg_we,
  output logic               wb_sel,
  output logic               instr_done,
  output logic               busy,
  output logic               fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  localparam logic [2:0] OP_LD   = 3'b000;
  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       is_ld, is_st, is_mem, use_imm, timeout;
  logic [2:0] exec_op;
  logic       unused_instr;

  assign is_ld   = (opcode_q == OP_LD);
  assign is_st   = (opcode_q == OP_ST);
  assign is_mem  = is_ld | is_st;
  assign use_imm = is_mem | (opcode_q == OP_ADDI) | (opcode_q == OP_SUBI);
  // Memory ops compute rs1+imm, so LD/ST opcodes never reach the ALU
  assign exec_op = is_mem ? OP_ADD : opcode_q;
  assign timeout = !mem_ready && (cnt_q == CNT_LAST);
  assign unused_instr = ^instr[INSTR_W-4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= 3'b000;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          opcode_d = instr[INSTR_W-1 -: 3];
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_mem) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_ld) begin
            state_d = S_WB;
          end else if (halt) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        if (halt) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    ir_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    instr_done = 1'b0;
    busy       = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        ir_we  = mem_ready;
        pc_en  = mem_ready;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy    = 1'b1;
        alu_op  = exec_op;
        alu_src = use_imm;
      end
      S_MEM: begin
        busy       = 1'b1;
        alu_op     = OP_ADD;
        alu_src    = 1'b1;
        addr_sel   = 1'b1;
        mem_rd     = is_ld;
        mem_wr     = is_st;
        instr_done = is_st & mem_ready;
      end
      S_WB: begin
        busy       = 1'b1;
        alu_op     = exec_op;
        alu_src    = use_imm;
        reg_we     = 1'b1;
        wb_sel     = is_ld;
        instr_done = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle output trace, which is compared against the DUT cycle by cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, mem_ready;
  logic [15:0] instr;
  logic        pc_en, ir_we, mem_rd, mem_wr, addr_sel, alu_src, reg_we, wb_sel;
  logic        instr_done, busy, fault;
  logic [2:0]  alu_op;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.INSTR_W(16), .MEM_TIMEOUT(8), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .instr(instr),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_we(ir_we), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .addr_sel(addr_sel), .alu_src(alu_src), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .instr_done(instr_done), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // bit order: pc_en ir_we mem_rd mem_wr addr_sel alu_src alu_op[3] reg_we wb_sel done busy fault
  logic [13:0] obs_vec;
  assign obs_vec = {pc_en, ir_we, mem_rd, mem_wr, addr_sel, alu_src, alu_op,
                    reg_we, wb_sel, instr_done, busy, fault};

  typedef struct {
    logic        rdy;
    logic        st;
    logic        hl;
    logic [15:0] ins;
    logic [13:0] want;
  } cyc_t;

  cyc_t        plan[$];
  logic [13:0] obs_q[$];
  logic        idle_m;

  function automatic logic [13:0] v(input logic pc, ir, rd, wr, as, src,
                                    input logic [2:0] op,
                                    input logic rwe, wbs, dn, bz, ft);
    return {pc, ir, rd, wr, as, src, op, rwe, wbs, dn, bz, ft};
  endfunction

  function automatic cyc_t rnd_cyc();
    cyc_t c;
    c.rdy  = 1'($urandom_range(0, 1));
    c.st   = 1'($urandom_range(0, 1));
    c.hl   = 1'($urandom_range(0, 1));
    c.ins  = 16'($urandom);
    c.want = '0;
    return c;
  endfunction

  // Expand one instruction (fw fetch wait cycles, mw memory wait cycles) into expected cycles
  task automatic add_instr(input logic [2:0] op, input int fw, input int mw, input logic hl);
    cyc_t c;
    logic ld, st_op, mem_op, imm;
    logic [2:0] aop;
    ld     = (op == 3'b000);
    st_op  = (op == 3'b001);
    mem_op = ld | st_op;
    imm    = mem_op | (op == 3'b110) | (op == 3'b111);
    aop    = mem_op ? 3'b010 : op;
    if (idle_m) begin
      c = rnd_cyc(); c.st = 1'b1; c.want = '0;
      plan.push_back(c);
    end
    for (int i = 0; i < fw; i++) begin
      c = rnd_cyc(); c.rdy = 1'b0;
      c.want = v(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
      plan.push_back(c);
    end
    c = rnd_cyc(); c.rdy = 1'b1; c.ins[15:13] = op;
    c.want = v(1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
    plan.push_back(c);
    c = rnd_cyc(); c.want = v(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
    plan.push_back(c);
    c = rnd_cyc(); c.want = v(0, 0, 0, 0, 0, imm, aop, 0, 0, 0, 1, 0);
    plan.push_back(c);
    if (mem_op) begin
      for (int i = 0; i < mw; i++) begin
        c = rnd_cyc(); c.rdy = 1'b0;
        c.want = v(0, 0, ld, st_op, 1, 1, 3'b010, 0, 0, 0, 1, 0);
        plan.push_back(c);
      end
      c = rnd_cyc(); c.rdy = 1'b1;
      c.want = v(0, 0, ld, st_op, 1, 1, 3'b010, 0, 0, st_op, 1, 0);
      plan.push_back(c);
    end
    if (!st_op) begin
      c = rnd_cyc(); c.want = v(0, 0, 0, 0, 0, imm, aop, 1, ld, 1, 1, 0);
      plan.push_back(c);
    end
    plan[plan.size()-1].hl = hl;
    idle_m = hl;
  endtask

  // Drives the first n planned cycles and records what the DUT showed on each
  task automatic run_plan(input int n);
    for (int i = 0; i < plan.size() && i < n; i++) begin
      start     = plan[i].st;
      halt      = plan[i].hl;
      mem_ready = plan[i].rdy;
      instr     = plan[i].ins;
      @(negedge clk);
      obs_q.push_back(obs_vec);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_plan();
    plan.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; mem_ready = 1'b0; instr = '0;
    #2;
    total++;
    if (obs_vec !== 14'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", obs_vec, 14'b0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (obs_vec !== 14'b0) begin
      bad++; $display("FAIL reset_idle: got %b want %b", obs_vec, 14'b0);
    end
    @(posedge clk); #1;
    idle_m = 1'b1;
    $display("reset: outputs checked in and after reset");
  endtask

  task automatic test_add();
    int di;
    clear_plan();
    add_instr(3'b010, 0, 0, 1'b1);
    run_plan(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL add cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
    end
    di = -1;
    for (int i = 0; i < obs_q.size(); i++) if (di < 0 && obs_q[i][2]) di = i;
    total++;
    if (di != 4) begin
      bad++; $display("FAIL add_latency: done at %0d want 4", di);
    end
    $display("add: %0d cycles compared", plan.size());
  endtask

  task automatic test_ld_wait();
    int di;
    clear_plan();
    add_instr(3'b000, 0, 3, 1'b1);
    run_plan(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL ld cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
    end
    di = -1;
    for (int i = 0; i < obs_q.size(); i++) if (di < 0 && obs_q[i][2]) di = i;
    total++;
    if (di != 8) begin
      bad++; $display("FAIL ld_latency: done at %0d want 8", di);
    end
    $display("ld wait3: %0d cycles compared", plan.size());
  endtask

  task automatic test_st();
    int di;
    int nwe;
    clear_plan();
    add_instr(3'b001, 0, 0, 1'b1);
    run_plan(plan.size());
    nwe = 0;
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL st cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
      if (obs_q[i][4]) nwe++;
    end
    di = -1;
    for (int i = 0; i < obs_q.size(); i++) if (di < 0 && obs_q[i][2]) di = i;
    total++;
    if (di != 4) begin
      bad++; $display("FAIL st_latency: done at %0d want 4", di);
    end
    total++;
    if (nwe != 0) begin
      bad++; $display("FAIL st_reg_we: reg_we cycles %0d want 0", nwe);
    end
    $display("st: %0d cycles compared", plan.size());
  endtask

  task automatic test_subi_halt();
    clear_plan();
    add_instr(3'b111, 0, 0, 1'b1);
    add_instr(3'b011, 1, 0, 1'b1);
    run_plan(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL subi_halt cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
    end
    $display("subi halt+restart: %0d cycles compared", plan.size());
  endtask

  task automatic test_boundary();
    clear_plan();
    add_instr(3'b000, 7, 7, 1'b1);
    add_instr(3'b001, 7, 7, 1'b1);
    run_plan(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL boundary cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
    end
    $display("ready on last allowed wait: %0d cycles compared", plan.size());
  endtask

  task automatic test_random();
    logic [2:0] op;
    int fw, mw;
    clear_plan();
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(0, 7));
      fw = ($urandom_range(0, 5) == 0) ? 7 : $urandom_range(0, 2);
      mw = $urandom_range(0, 7);
      add_instr(op, fw, mw, (k == 29) ? 1'b1 : ($urandom_range(0, 3) == 0));
    end
    run_plan(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL random cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
    end
    $display("random: 30 instructions, %0d cycles compared", plan.size());
  endtask

  task automatic test_reset_mid_mem();
    clear_plan();
    add_instr(3'b000, 0, 5, 1'b1);
    run_plan(6);
    mem_ready = 1'b0;
    total++;
    if (mem_rd !== 1'b1) begin
      bad++; $display("FAIL midmem_rd: got %b want 1", mem_rd);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_vec !== 14'b0) begin
      bad++; $display("FAIL midmem_async: got %b want %b", obs_vec, 14'b0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle_m = 1'b1;
    clear_plan();
    begin
      cyc_t c;
      c = rnd_cyc(); c.st = 1'b0; c.want = '0;
      plan.push_back(c);
    end
    add_instr(3'b101, 0, 0, 1'b1);
    run_plan(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL after_reset cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
    end
    $display("reset mid-MEM: async clear and restart checked");
  endtask

  task automatic test_timeout();
    cyc_t c;
    clear_plan();
    c = rnd_cyc(); c.st = 1'b1; c.want = '0;
    plan.push_back(c);
    for (int i = 0; i < 8; i++) begin
      c = rnd_cyc(); c.rdy = 1'b0;
      c.want = v(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
      plan.push_back(c);
    end
    for (int i = 0; i < 6; i++) begin
      c = rnd_cyc(); c.st = 1'b1;
      c.want = v(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
      plan.push_back(c);
    end
    run_plan(plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      total++;
      if (obs_q[i] !== plan[i].want) begin
        bad++; $display("FAIL timeout cyc%0d: got %b want %b", i, obs_q[i], plan[i].want);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL fault_clear: got %b want 0", fault);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle_m = 1'b1;
    $display("timeout: fault after 8 waits, sticky, cleared by reset");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_ld_wait();
    test_st();
    test_subi_halt();
    test_boundary();
    test_random();
    test_reset_mid_mem();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
